// File: rtl/key_conditioner.sv
// Key front end: synchronise, debounce and edge-detect active-low buttons
// into a debounced level plus one-cycle press/release/long-press strobes.
module key_conditioner #(
  parameter int NUM_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  localparam int MAX_CYC =
    (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
    DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LP_LAST =
    CW'((LONG_PRESS_CYCLES > 0) ? LONG_PRESS_CYCLES - 1 : 0);
  localparam bit LP_EN = (LONG_PRESS_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [1:0]    sync;
    logic          s;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          flag, flag_nx;
    logic          lvl, lvl_nx;
    logic          prs, prs_nx;
    logic          rel, rel_nx;
    logic          lng, lng_nx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= 2'b11;
      end else begin
        sync <= {sync[0], key_n[i]};
      end
    end

    assign s = ~sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        flag  <= 1'b0;
        lvl   <= 1'b0;
        prs   <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        flag  <= flag_nx;
        lvl   <= lvl_nx;
        prs   <= prs_nx;
        rel   <= rel_nx;
        lng   <= lng_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      flag_nx  = flag;
      lvl_nx   = lvl;
      prs_nx   = 1'b0;
      rel_nx   = 1'b0;
      lng_nx   = 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state_nx = DB_PRESS;
            cnt_nx   = CW'(1);
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == DB_LAST) begin
            state_nx = HELD;
            cnt_nx   = '0;
            flag_nx  = 1'b0;
            lvl_nx   = 1'b1;
            prs_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_nx = DB_RELEASE;
            cnt_nx   = CW'(1);
          end else if (LP_EN && !flag) begin
            // counter parks at the terminal value once long fires
            if (cnt == LP_LAST) begin
              lng_nx  = 1'b1;
              flag_nx = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (s) begin
            state_nx = HELD;
            cnt_nx   = '0;
          end else if (cnt == DB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            lvl_nx   = 1'b0;
            rel_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign key_level[i]     = lvl;
    assign press_pulse[i]   = prs;
    assign release_pulse[i] = rel;
    assign long_pulse[i]    = lng;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: DEBOUNCE=4, LONG_PRESS=10.
// Edge numbers count from the first posedge after a key change.
module tb_key_conditioner;
  localparam int NK = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_pulse;

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int pc[NK], lc[NK], rc[NK];
  int pe[NK], le[NK], re[NK];
  int lv[NK];
  int mp;

  typedef struct {
    int key;
    int hold;
    int np;
    int nl;
    int nr;
    int ep;
    int el;
    int er;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run(input logic [NK-1:0] mask,
                     input logic [63:0] pat, input int n);
    for (int k = 0; k < NK; k++) begin
      pc[k] = 0; lc[k] = 0; rc[k] = 0;
      pe[k] = -1; le[k] = -1; re[k] = -1;
      lv[k] = 0;
    end
    mp = 0;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < NK; k++)
        if (mask[k]) key_n[k] = ~pat[t];
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (press_pulse[k]) begin
          pc[k]++;
          if (pe[k] < 0) pe[k] = t;
        end
        if (long_pulse[k]) begin
          lc[k]++;
          if (le[k] < 0) le[k] = t;
        end
        if (release_pulse[k]) begin
          rc[k]++;
          if (re[k] < 0) re[k] = t;
        end
        if (key_level[k]) lv[k] = 1;
        if (int'(press_pulse[k]) + int'(long_pulse[k])
            + int'(release_pulse[k]) > 1) mp++;
      end
    end
    for (int k = 0; k < NK; k++)
      if (mask[k]) key_n[k] = 1'b1;
  endtask

  initial begin
    logic [63:0] pat;
    int others;

    tbl[0] = '{0,  3, 0, 0, 0, -1, -1, -1};
    tbl[1] = '{1,  4, 1, 0, 1,  5, -1,  9};
    tbl[2] = '{2,  8, 1, 0, 1,  5, -1, 13};
    tbl[3] = '{0, 13, 1, 0, 1,  5, -1, 18};
    tbl[4] = '{1, 14, 1, 1, 1,  5, 15, 19};
    tbl[5] = '{2, 30, 1, 1, 1,  5, 15, 35};

    #12;
    chk("rst key_level", int'(key_level), 0);
    chk("rst press", int'(press_pulse), 0);
    chk("rst release", int'(release_pulse), 0);
    chk("rst long", int'(long_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean press then release on key 0, checked edge by edge
    key_n[0] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      chk($sformatf("clean press e%0d", e),
          int'(press_pulse), (e == 5) ? 1 : 0);
      chk($sformatf("clean level e%0d", e),
          int'(key_level), (e >= 5) ? 1 : 0);
      chk($sformatf("clean long e%0d", e), int'(long_pulse), 0);
    end
    key_n[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      chk($sformatf("clean release e%0d", e),
          int'(release_pulse), (e == 5) ? 1 : 0);
      chk($sformatf("clean rlevel e%0d", e),
          int'(key_level), (e < 5) ? 1 : 0);
    end

    foreach (tbl[i]) begin
      pat = (64'h1 << tbl[i].hold) - 64'h1;
      run(NK'(1) << tbl[i].key, pat, tbl[i].hold + 12);
      chk($sformatf("v%0d press cnt", i), pc[tbl[i].key], tbl[i].np);
      chk($sformatf("v%0d long cnt", i), lc[tbl[i].key], tbl[i].nl);
      chk($sformatf("v%0d rel cnt", i), rc[tbl[i].key], tbl[i].nr);
      chk($sformatf("v%0d press edge", i), pe[tbl[i].key], tbl[i].ep);
      chk($sformatf("v%0d long edge", i), le[tbl[i].key], tbl[i].el);
      chk($sformatf("v%0d rel edge", i), re[tbl[i].key], tbl[i].er);
      others = 0;
      for (int k = 0; k < NK; k++)
        if (k != tbl[i].key) others += pc[k] + lc[k] + rc[k] + lv[k];
      chk($sformatf("v%0d other keys", i), others, 0);
      chk($sformatf("v%0d multi pulse", i), mp, 0);
    end

    // bounce: low 3, high 1, low 3, then high
    run(3'b010, 64'h77, 14);
    chk("bounce press", pc[1], 0);
    chk("bounce level", lv[1], 0);
    chk("bounce release", rc[1], 0);
    run(3'b010, 64'h3F, 16);
    chk("after bounce press", pc[1], 1);
    chk("after bounce press edge", pe[1], 5);
    chk("after bounce rel edge", re[1], 11);

    // 2-edge release glitch mid-hold restarts the long timer
    pat = ((64'h1 << 40) - 64'h1) & ~64'h300;
    run(3'b100, pat, 50);
    chk("glitch press", pc[2], 1);
    chk("glitch release cnt", rc[2], 1);
    chk("glitch release edge", re[2], 45);
    chk("glitch long cnt", lc[2], 1);
    chk("glitch long edge", le[2], 22);

    // all keys fall together
    run(3'b111, 64'hFF, 20);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("simul press edge k%0d", k), pe[k], 5);
      chk($sformatf("simul rel edge k%0d", k), re[k], 13);
    end

    // reset while held: level drops, lost press never releases
    key_n[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("held level pre-reset", int'(key_level), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-hold rst level", int'(key_level), 0);
    chk("mid-hold rst pulses",
        int'(press_pulse | release_pulse | long_pulse), 0);
    key_n[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b001, 64'h0, 12);
    chk("lost press release", rc[0], 0);
    chk("lost press press", pc[0], 0);

    // reset in DB_PRESS with cnt=2, key still down afterwards
    key_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("db pre-reset press", int'(press_pulse), 0);
    rst_n = 1'b0;
    #1;
    chk("db rst outputs",
        int'({key_level, press_pulse, release_pulse, long_pulse}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b001, 64'hFFFF, 10);
    chk("post-rst press cnt", pc[0], 1);
    chk("post-rst press edge", pe[0], 5);
    run(3'b001, 64'h0, 10);
    chk("post-rst release edge", re[0], 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
